fu_mult_pipe: RTL and testbench

Parametrised, fully pipelined RV32M multiply functional unit for the R10K out-of-order core; successor to the fixed-depth `fu_mult`. It sits between the issue stage and the complete stage. It accepts one `ISSUE_FU_PACKET` per cycle and executes all four multiply ops (MUL, MULH, MULHSU, MULHU) through `NUM_STAGE` partial-product stages. It returns one `FU_COMPLETE_PACKET` per cycle, in order. It compresses bubbles under `complete_stall` and flushes in-flight work on `squash`.

---
 rtl/sys_defs.sv | 65 ++++++
 rtl/mult_stage.sv | 49 ++++
 rtl/fu_mult_pipe.sv | 103 ++++++++++
 tb/tb_fu_mult_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared types for the R10K execute path.
// Issue/complete packets plus the multiply pipeline stage bundle.
package sys_defs;

    localparam int SYS_XLEN  = 32;
    localparam int ROB_IDX_W = 5;
    localparam int PR_IDX_W  = 6;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        MULT_FUNC mult;
    } FU_OP_SEL;

    typedef struct packed {
        logic                 valid;
        FU_OP_SEL             op_sel;
        logic [SYS_XLEN-1:0]  r1_value;
        logic [SYS_XLEN-1:0]  r2_value;
        logic [ROB_IDX_W-1:0] rob_entry;
        logic [PR_IDX_W-1:0]  dest_pr;
        logic                 halt;
        logic [SYS_XLEN-1:0]  PC;
        logic [SYS_XLEN-1:0]  NPC;
    } ISSUE_FU_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [SYS_XLEN-1:0]  dest_value;
        logic [ROB_IDX_W-1:0] rob_entry;
        logic [PR_IDX_W-1:0]  dest_pr;
        logic                 halt;
        logic                 if_take_branch;
        logic [SYS_XLEN-1:0]  target_pc;
        logic [SYS_XLEN-1:0]  PC;
        logic [SYS_XLEN-1:0]  NPC;
    } FU_COMPLETE_PACKET;

    typedef struct packed {
        logic                  valid;
        MULT_FUNC              func;
        logic [2*SYS_XLEN-1:0] mcand;
        logic [2*SYS_XLEN-1:0] mplier;
        logic [2*SYS_XLEN-1:0] psum;
        logic [ROB_IDX_W-1:0]  rob_entry;
        logic [PR_IDX_W-1:0]   dest_pr;
        logic                  halt;
        logic [SYS_XLEN-1:0]   PC;
        logic [SYS_XLEN-1:0]   NPC;
    } MULT_STAGE_PACKET;

    // Widen an operand to the double-width product domain.
    function automatic logic [2*SYS_XLEN-1:0] mult_ext(
        input logic [SYS_XLEN-1:0] v,
        input logic                sgn
    );
        return {{SYS_XLEN{sgn & v[SYS_XLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One partial-product step of the multiply pipeline.
// Adds slice IDX of the multiplier and holds the result under back-pressure.
module mult_stage
    import sys_defs::*;
#(
    parameter int XLEN      = SYS_XLEN,
    parameter int NUM_STAGE = 4,
    parameter int IDX       = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             i_next_load,
    input  MULT_STAGE_PACKET i_prev,
    output logic             o_load,
    output MULT_STAGE_PACKET o_stage
);

    localparam int DW = 2 * XLEN;
    localparam int W  = DW / NUM_STAGE;

    MULT_STAGE_PACKET r_stage;
    MULT_STAGE_PACKET w_step;
    logic [DW-1:0]    w_slice;

    // An empty stage always accepts; a full one only when it drains onward.
    assign o_load  = !r_stage.valid || i_next_load;
    assign o_stage = r_stage;
    assign w_slice = DW'(i_prev.mplier[IDX*W +: W]);

    // Accumulate this stage's shifted partial product; wraps at DW bits.
    always_comb begin
        w_step      = i_prev;
        w_step.psum = i_prev.psum
                    + ((i_prev.mcand << (IDX * W)) * w_slice);
    end

    // Stage register: reset wipes data, squash only drops the op.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage <= '0;
        end else if (squash) begin
            r_stage.valid <= 1'b0;
        end else if (o_load) begin
            r_stage <= w_step;
        end
    end

endmodule

// File: rtl/fu_mult_pipe.sv
// Pipelined RV32M multiply unit between issue and complete.
// Extends operands, chains the stage advance logic and formats results.
module fu_mult_pipe
    import sys_defs::*;
#(
    parameter int XLEN      = SYS_XLEN,
    parameter int NUM_STAGE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic              complete_stall,
    input  ISSUE_FU_PACKET    fu_packet_in,
    output logic              fu_ready,
    output logic              want_to_complete,
    output FU_COMPLETE_PACKET fu_packet_out
);

    localparam int DW = 2 * XLEN;

    logic             w_r1_sgn;
    logic             w_r2_sgn;
    MULT_STAGE_PACKET w_issue;
    MULT_STAGE_PACKET w_in  [NUM_STAGE];
    MULT_STAGE_PACKET w_out [NUM_STAGE];
    MULT_STAGE_PACKET w_last;
    logic [NUM_STAGE:0] w_load;
    logic             w_unused;

    // Operand signedness selected by the multiply flavour.
    always_comb begin
        w_r1_sgn = 1'b0;
        w_r2_sgn = 1'b0;
        case (fu_packet_in.op_sel.mult)
            MUL, MULH: begin
                w_r1_sgn = 1'b1;
                w_r2_sgn = 1'b1;
            end
            MULHSU:  w_r1_sgn = 1'b1;
            default: ;
        endcase
    end

    // Stage-0 input bundle: extended operands, empty sum, metadata.
    always_comb begin
        w_issue           = '0;
        w_issue.valid     = fu_packet_in.valid;
        w_issue.func      = fu_packet_in.op_sel.mult;
        w_issue.mcand     = mult_ext(fu_packet_in.r1_value, w_r1_sgn);
        w_issue.mplier    = mult_ext(fu_packet_in.r2_value, w_r2_sgn);
        w_issue.rob_entry = fu_packet_in.rob_entry;
        w_issue.dest_pr   = fu_packet_in.dest_pr;
        w_issue.halt      = fu_packet_in.halt;
        w_issue.PC        = fu_packet_in.PC;
        w_issue.NPC       = fu_packet_in.NPC;
    end

    assign w_load[NUM_STAGE] = !complete_stall;

    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_in[i] = w_issue;
        end else begin : g_body
            assign w_in[i] = w_out[i-1];
        end

        mult_stage #(
            .XLEN      (XLEN),
            .NUM_STAGE (NUM_STAGE),
            .IDX       (i)
        ) u_stage (
            .clock       (clock),
            .reset       (reset),
            .squash      (squash),
            .i_next_load (w_load[i+1]),
            .i_prev      (w_in[i]),
            .o_load      (w_load[i]),
            .o_stage     (w_out[i])
        );
    end

    assign w_last           = w_out[NUM_STAGE-1];
    assign fu_ready         = w_load[0];
    assign want_to_complete = w_last.valid;
    assign w_unused         = ^{w_last.mcand, w_last.mplier};

    // Result packet; forced to zero whenever the last stage is empty.
    always_comb begin
        fu_packet_out = '0;
        if (w_last.valid) begin
            fu_packet_out.valid      = 1'b1;
            fu_packet_out.dest_value = (w_last.func == MUL)
                                     ? w_last.psum[XLEN-1:0]
                                     : w_last.psum[DW-1:XLEN];
            fu_packet_out.rob_entry  = w_last.rob_entry;
            fu_packet_out.dest_pr    = w_last.dest_pr;
            fu_packet_out.halt       = w_last.halt;
            fu_packet_out.PC         = w_last.PC;
            fu_packet_out.NPC        = w_last.NPC;
        end
    end

endmodule

// File: tb/tb_fu_mult_pipe.sv
// Bench for fu_mult_pipe at depths 4, 1, 2 and 8.
// Each depth runs the same directed and random sequence against a queue model.
module tb_fu_mult_pipe;
    import sys_defs::*;

    localparam int NI = 4;
    localparam int CW = 192;

    typedef struct {
        FU_COMPLETE_PACKET pkt;
        int                avail;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst [NI];
    logic              sq  [NI];
    logic              stl [NI];
    logic              rdy [NI];
    logic              wtc [NI];
    ISSUE_FU_PACKET    pin  [NI];
    FU_COMPLETE_PACKET pout [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NS = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
        fu_mult_pipe #(
            .XLEN      (32),
            .NUM_STAGE (NS)
        ) u_dut (
            .clock            (clock),
            .reset            (rst[g]),
            .squash           (sq[g]),
            .complete_stall   (stl[g]),
            .fu_packet_in     (pin[g]),
            .fu_ready         (rdy[g]),
            .want_to_complete (wtc[g]),
            .fu_packet_out    (pout[g])
        );
    end

    int          cur;
    int          n;
    int          n_cmp;
    int          n_bad;
    int          edge_n;
    string       phase;
    exp_t        q[$];
    logic [31:0] seen_v[$];
    int          seen_e[$];
    logic [31:0] bexp [4];

    function automatic int ns_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] ref_mult(input MULT_FUNC f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (f == MUL || f == MULH) p = sa * sb;
        else if (f == MULHSU)      p = sa * ub;
        else                       p = ua * ub;
        pb = p;
        return (f == MUL) ? pb[31:0] : pb[63:32];
    endfunction

    function automatic FU_COMPLETE_PACKET mk_exp(input ISSUE_FU_PACKET p);
        FU_COMPLETE_PACKET e;
        e            = '0;
        e.valid      = 1'b1;
        e.dest_value = ref_mult(p.op_sel.mult, p.r1_value, p.r2_value);
        e.rob_entry  = p.rob_entry;
        e.dest_pr    = p.dest_pr;
        e.halt       = p.halt;
        e.PC         = p.PC;
        e.NPC        = p.NPC;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs,
                       input logic [CW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s/%s ns=%0d: observed %h expected %h",
                   phase, tag, n, obs, exp);
        end
    endtask

    task automatic issue(input MULT_FUNC f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rob,
                         input logic [5:0] pr);
        pin[cur].valid       = 1'b1;
        pin[cur].op_sel.mult = f;
        pin[cur].r1_value    = a;
        pin[cur].r2_value    = b;
        pin[cur].rob_entry   = rob;
        pin[cur].dest_pr     = pr;
        pin[cur].halt        = 1'($urandom_range(0, 1));
        pin[cur].PC          = $urandom;
        pin[cur].NPC         = pin[cur].PC + 32'd4;
    endtask

    task automatic issue_rand();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) b = 32'hffff_ffff;
        issue(MULT_FUNC'($urandom_range(0, 3)), a, b,
              5'($urandom), 6'($urandom));
    endtask

    task automatic idle();
        pin[cur].valid = 1'b0;
    endtask

    // Check outputs against the queue model, then take one clock edge.
    task automatic cyc();
        logic              want, exp_rdy, cap, pop;
        FU_COMPLETE_PACKET exp_out;
        exp_t              ent;
        #1;
        want    = (q.size() > 0) && (edge_n >= q[0].avail);
        exp_rdy = !(stl[cur] && (q.size() == n));
        exp_out = want ? q[0].pkt : '0;
        chk("ready", CW'(rdy[cur]), CW'(exp_rdy));
        chk("want", CW'(wtc[cur]), CW'(want));
        chk("pkt", CW'(pout[cur]), CW'(exp_out));
        cap = pin[cur].valid && exp_rdy && !sq[cur] && !rst[cur];
        pop = want && !stl[cur];
        ent.pkt   = mk_exp(pin[cur]);
        ent.avail = 0;
        if (wtc[cur] && !stl[cur] && !rst[cur] && !sq[cur]) begin
            seen_v.push_back(pout[cur].dest_value);
            seen_e.push_back(edge_n + 1);
        end
        @(posedge clock);
        edge_n++;
        if (rst[cur] || sq[cur]) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (cap) begin
                ent.avail = edge_n + n - 1;
                q.push_back(ent);
            end
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int b;
        b = 0;
        stl[cur] = 1'b0;
        idle();
        while (q.size() > 0 && b < 64) begin
            cyc();
            b++;
        end
        chk("drain_left", CW'(q.size()), CW'(0));
        cyc();
    endtask

    initial begin
        int dly;
        n_cmp   = 0;
        n_bad   = 0;
        edge_n  = 0;
        bexp[0] = 32'h0000_0001;
        bexp[1] = 32'h0000_0000;
        bexp[2] = 32'hffff_ffff;
        bexp[3] = 32'hffff_fffe;
        for (int d = 0; d < NI; d++) begin
            rst[d] = 1'b1;
            sq[d]  = 1'b0;
            stl[d] = 1'b0;
            pin[d] = '0;
        end
        repeat (2) @(negedge clock);
        for (int d = 0; d < NI; d++) rst[d] = 1'b0;

        for (int d = 0; d < NI; d++) begin
            cur = d;
            n   = ns_of(d);
            q.delete();

            phase = "reset";
            #1;
            chk("ready", CW'(rdy[cur]), CW'(1'b1));
            chk("want", CW'(wtc[cur]), CW'(1'b0));
            chk("pkt", CW'(pout[cur]), CW'(0));

            phase = "basic";
            issue(MUL, 32'h0000_1f1e, 32'hffff_ffff, 5'd6, 6'd32);
            cyc();
            idle();
            for (int k = 1; k < n; k++) cyc();
            #1;
            chk("value", CW'(pout[cur].dest_value), CW'(32'hffff_e0e2));
            chk("rob", CW'(pout[cur].rob_entry), CW'(5'd6));
            chk("pr", CW'(pout[cur].dest_pr), CW'(6'd32));
            chk("valid", CW'(pout[cur].valid), CW'(1'b1));
            cyc();
            #1;
            chk("one_cycle", CW'(wtc[cur]), CW'(1'b0));
            cyc();

            phase = "variants";
            seen_v.delete();
            seen_e.delete();
            for (int i = 0; i < 4; i++) begin
                issue(MULT_FUNC'(i), 32'hffff_ffff, 32'hffff_ffff,
                      5'(i + 1), 6'(i + 10));
                #1;
                chk("ready_held", CW'(rdy[cur]), CW'(1'b1));
                cyc();
            end
            drain();
            chk("count", CW'(seen_v.size()), CW'(4));
            for (int i = 0; i < 4 && i < seen_v.size(); i++)
                chk("value", CW'(seen_v[i]), CW'(bexp[i]));
            if (seen_e.size() == 4)
                chk("back_to_back", CW'(seen_e[3] - seen_e[0]), CW'(3));

            phase = "stall";
            seen_v.delete();
            seen_e.delete();
            stl[cur] = 1'b1;
            issue(MUL, 32'h8930_1f1e, 32'hffff_ffff, 5'd3, 6'd7);
            cyc();
            for (int k = 1; k < n; k++) begin
                issue_rand();
                cyc();
            end
            issue_rand();
            #1;
            chk("ready_low", CW'(rdy[cur]), CW'(1'b0));
            for (int k = 0; k < 3; k++) begin
                cyc();
                #1;
                chk("hold", CW'(pout[cur].dest_value), CW'(32'h76cf_e0e2));
                chk("ready_low", CW'(rdy[cur]), CW'(1'b0));
            end
            stl[cur] = 1'b0;
            #1;
            chk("release_ready", CW'(rdy[cur]), CW'(1'b1));
            cyc();
            drain();
            chk("count", CW'(seen_v.size()), CW'(n + 1));
            if (seen_v.size() == n + 1) begin
                chk("first", CW'(seen_v[0]), CW'(32'h76cf_e0e2));
                chk("drain_rate", CW'(seen_e[n] - seen_e[0]), CW'(n));
            end

            phase = "squash";
            seen_v.delete();
            seen_e.delete();
            dly = (n > 2) ? 2 : n - 1;
            issue_rand();
            if (dly == 0) sq[cur] = 1'b1;
            cyc();
            idle();
            for (int i = 1; i <= dly; i++) begin
                if (i == dly) sq[cur] = 1'b1;
                cyc();
            end
            sq[cur] = 1'b0;
            #1;
            chk("want_after", CW'(wtc[cur]), CW'(1'b0));
            issue(MULHU, 32'h0001_0000, 32'h0001_0000, 5'd9, 6'd12);
            cyc();
            idle();
            for (int k = 0; k < n + 2; k++) cyc();
            chk("completions", CW'(seen_v.size()), CW'(1));
            if (seen_v.size() == 1)
                chk("survivor", CW'(seen_v[0]), CW'(32'h0000_0001));

            phase = "squash_stall";
            stl[cur] = 1'b1;
            for (int k = 0; k < n; k++) begin
                issue_rand();
                cyc();
            end
            idle();
            sq[cur] = 1'b1;
            cyc();
            sq[cur] = 1'b0;
            #1;
            chk("ready", CW'(rdy[cur]), CW'(1'b1));
            chk("want", CW'(wtc[cur]), CW'(1'b0));

            phase = "reset_mid";
            for (int k = 0; k < n; k++) begin
                issue_rand();
                cyc();
            end
            idle();
            #1;
            chk("full", CW'(rdy[cur]), CW'(1'b0));
            rst[cur] = 1'b1;
            cyc();
            rst[cur] = 1'b0;
            #1;
            chk("ready", CW'(rdy[cur]), CW'(1'b1));
            chk("want", CW'(wtc[cur]), CW'(1'b0));
            chk("pkt", CW'(pout[cur]), CW'(0));
            stl[cur] = 1'b0;
            cyc();

            phase = "random";
            for (int k = 0; k < 80; k++) begin
                if ($urandom_range(0, 9) < 7) issue_rand();
                else idle();
                stl[cur] = ($urandom_range(0, 9) < 3);
                sq[cur]  = ($urandom_range(0, 39) == 0);
                cyc();
            end
            sq[cur] = 1'b0;
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
